// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer: FSM state encoding,
// opcode values and a small decode helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_DECODE     = 3'd3,
    ST_EXEC       = 3'd4,
    ST_HALT       = 3'd5
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Opcodes whose operand addresses a RAM word to be read during DECODE/EXEC.
  function automatic logic is_mem_read(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// 8-bit adder/subtractor. For subtraction, carry_o reports "no borrow" (a >= b).
module cpu_alu (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       sub_i,
  output logic [7:0] result_o,
  output logic       carry_o,
  output logic       zero_o
);

  logic [8:0] sum_s;

  // Two's-complement subtract reuses the adder so bit 8 is the inverted borrow.
  always_comb begin
    if (sub_i) begin
      sum_s = {1'b0, a_i} + {1'b0, ~b_i} + 9'd1;
    end else begin
      sum_s = {1'b0, a_i} + {1'b0, b_i};
    end
    result_o = sum_s[7:0];
    carry_o  = sum_s[8];
    zero_o   = (sum_s[7:0] == 8'd0);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle accumulator CPU: FETCH, FETCH_WAIT, DECODE, EXEC per instruction,
// against a RAM with one cycle of registered read latency.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [3:0] RESET_PC = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] mem_address,
  output logic       mem_we,
  output logic       mem_re,
  output logic [7:0] mem_dataIn,
  input  logic [7:0] mem_dataOut,
  output logic [7:0] out_value,
  output logic       out_valid,
  output logic       halted,
  output logic [3:0] pc
);

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] outr_q, outr_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       out_valid_q, out_valid_d;

  logic [3:0] opcode_s;
  logic [3:0] operand_s;
  logic [7:0] alu_res_s;
  logic       alu_c_s;
  logic       alu_z_s;

  assign opcode_s  = ir_q[7:4];
  assign operand_s = ir_q[3:0];

  cpu_alu u_alu (
    .a_i      (a_q),
    .b_i      (mem_dataOut),
    .sub_i    (opcode_s == OP_SUB),
    .result_o (alu_res_s),
    .carry_o  (alu_c_s),
    .zero_o   (alu_z_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= 8'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      outr_q      <= 8'd0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      outr_q      <= outr_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, datapath updates and RAM strobes (decoded from registered state only).
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    outr_d      = outr_q;
    c_d         = c_q;
    z_d         = z_q;
    out_valid_d = 1'b0;
    mem_address = 4'd0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = start ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        mem_address = pc_q;
        mem_re      = 1'b1;
        state_d     = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        mem_address = pc_q;
        mem_re      = 1'b1;
        ir_d        = mem_dataOut;
        pc_d        = pc_q + 4'd1;
        state_d     = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_mem_read(opcode_s)) begin
          mem_address = operand_s;
          mem_re      = 1'b1;
        end else if (opcode_s == OP_STA) begin
          mem_address = operand_s;
          mem_we      = 1'b1;
        end else begin
          mem_address = 4'd0;
        end
        // OUTR is loaded here so out_value is already valid while out_valid pulses in EXEC.
        if (opcode_s == OP_OUT) begin
          outr_d      = a_q;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
        state_d = (opcode_s == OP_HLT) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        if (is_mem_read(opcode_s)) begin
          mem_address = operand_s;
          mem_re      = 1'b1;
        end else begin
          mem_address = 4'd0;
        end
        case (opcode_s)
          OP_LDA: begin
            a_d = mem_dataOut;
            z_d = (mem_dataOut == 8'd0);
          end
          OP_ADD, OP_SUB: begin
            b_d = mem_dataOut;
            a_d = alu_res_s;
            c_d = alu_c_s;
            z_d = alu_z_s;
          end
          OP_LDI: begin
            a_d = {4'b0000, operand_s};
            z_d = (operand_s == 4'd0);
          end
          OP_JMP: pc_d = operand_s;
          OP_JC:  pc_d = c_q ? operand_s : pc_q;
          OP_JZ:  pc_d = z_q ? operand_s : pc_q;
          default: pc_d = pc_q;
        endcase
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_dataIn = a_q;
  assign out_value  = outr_q;
  assign out_valid  = out_valid_q;
  assign halted     = (state_q == ST_HALT);
  assign pc         = pc_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: behavioural RAM, output/write scoreboards
// and directed programs.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] mem_address;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_dataIn;
  logic [7:0] mem_dataOut = 8'h00;
  logic [7:0] out_value;
  logic       out_valid;
  logic       halted;
  logic [3:0] pc;

  logic [7:0]  ram [16];
  logic [7:0]  img [16];
  logic        load;
  logic [7:0]  exp_out[$];
  logic [11:0] exp_wr[$];
  int          out_cnt;
  int          wr_cnt;
  logic        both_seen;
  int          n_tests = 0;
  int          n_fail  = 0;

  cpu_sequencer #(.RESET_PC(4'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_address (mem_address),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut),
    .out_value   (out_value),
    .out_valid   (out_valid),
    .halted      (halted),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RAM with registered read; image load happens only while the bench holds load.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) ram[i] <= img[i];
    end else begin
      if (mem_we) ram[mem_address] <= mem_dataIn;
      if (mem_re && !mem_we) mem_dataOut <= ram[mem_address];
    end
  end

  // Scoreboard monitor: outputs and RAM writes compared against expected queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we && mem_re) both_seen = 1'b1;
      if (out_valid) begin
        out_cnt++;
        if (exp_out.size() > 0) check_eq("out_value", {24'd0, out_value}, {24'd0, exp_out.pop_front()});
        else check_eq("out_unexpected", 32'd1, 32'd0);
      end
      if (mem_we) begin
        wr_cnt++;
        if (exp_wr.size() > 0) check_eq("ram_write", {20'd0, mem_address, mem_dataIn}, {20'd0, exp_wr.pop_front()});
        else check_eq("write_unexpected", 32'd1, 32'd0);
      end
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  task automatic reset_and_load();
    reset = 1'b1;
    start = 1'b0;
    load  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    reset     = 1'b0;
    out_cnt   = 0;
    wr_cnt    = 0;
    both_seen = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic finish_run(input string tag, input logic [3:0] exp_pc, input int exp_outs, input int exp_wrs);
    check_eq({tag, "_pc"}, {28'd0, pc}, {28'd0, exp_pc});
    check_eq({tag, "_outs"}, out_cnt, exp_outs);
    check_eq({tag, "_writes"}, wr_cnt, exp_wrs);
    check_eq({tag, "_pending"}, exp_out.size() + exp_wr.size(), 32'd0);
    check_eq({tag, "_we_re_excl"}, {31'd0, both_seen}, 32'd0);
    exp_out.delete();
    exp_wr.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    load  = 1'b0;
    out_cnt = 0;
    wr_cnt = 0;
    both_seen = 1'b0;
    #3;
    check_eq("rst_pc", {28'd0, pc}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    check_eq("rst_out_value", {24'd0, out_value}, 32'd0);
    check_eq("rst_acc", {24'd0, mem_dataIn}, 32'd0);

    // LDA 10, ADD 11, OUT, HLT with 3 + 2.
    clear_img();
    img[0] = 8'h1A; img[1] = 8'h2B; img[2] = 8'hE0; img[3] = 8'hF0;
    img[10] = 8'd3; img[11] = 8'd2;
    exp_out.push_back(8'd5);
    reset_and_load();
    repeat (3) @(posedge clk);
    #1 check_eq("idle_no_re", {31'd0, mem_re}, 32'd0);
    pulse_start();
    run_to_halt(80);
    finish_run("add", 4'd4, 1, 0);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check_eq("halt_sticky", {31'd0, halted}, 32'd1);
    check_eq("halt_no_re", {30'd0, mem_we, mem_re}, 32'd0);
    check_eq("halt_pc", {28'd0, pc}, 32'd4);

    // LDI 7, STA 12, LDA 12, OUT, HLT.
    clear_img();
    img[0] = 8'h57; img[1] = 8'h4C; img[2] = 8'h1C; img[3] = 8'hE0; img[4] = 8'hF0;
    exp_wr.push_back({4'd12, 8'd7});
    exp_out.push_back(8'd7);
    reset_and_load();
    pulse_start();
    run_to_halt(80);
    finish_run("sta", 4'd5, 1, 1);
    check_eq("sta_ram12", {24'd0, ram[12]}, 32'd7);

    // LDI 2, SUB 9, JC 5, OUT, HLT, HLT with a borrow: no jump, 0xFF out.
    clear_img();
    img[0] = 8'h52; img[1] = 8'h39; img[2] = 8'h75; img[3] = 8'hE0; img[4] = 8'hF0; img[5] = 8'hF0;
    img[9] = 8'd3;
    exp_out.push_back(8'hFF);
    reset_and_load();
    pulse_start();
    run_to_halt(80);
    finish_run("sub_borrow", 4'd5, 1, 0);

    // Same program without a borrow: jump taken to HLT at 5.
    img[9] = 8'd1;
    reset_and_load();
    pulse_start();
    run_to_halt(80);
    finish_run("sub_nob", 4'd6, 0, 0);

    // LDI 0, JZ 3, OUT (skipped), LDI 9, OUT, HLT.
    clear_img();
    img[0] = 8'h50; img[1] = 8'h83; img[2] = 8'hE0; img[3] = 8'h59; img[4] = 8'hE0; img[5] = 8'hF0;
    exp_out.push_back(8'd9);
    reset_and_load();
    pulse_start();
    run_to_halt(80);
    finish_run("jz", 4'd6, 1, 0);

    // 200 + 100 carries out: JC 5 taken, OUT 0x2C, HLT at 6.
    clear_img();
    img[0] = 8'h1A; img[1] = 8'h2B; img[2] = 8'h75; img[3] = 8'hE0; img[4] = 8'hF0;
    img[5] = 8'hE0; img[6] = 8'hF0; img[10] = 8'd200; img[11] = 8'd100;
    exp_out.push_back(8'h2C);
    reset_and_load();
    pulse_start();
    run_to_halt(80);
    finish_run("carry", 4'd7, 1, 0);

    // 15 NOPs then JMP 0: FETCH every 4 cycles at addresses 0..15 and back to 0.
    clear_img();
    img[15] = 8'h60;
    reset_and_load();
    pulse_start();
    for (int i = 0; i <= 16; i++) begin
      check_eq("nop_pc", {28'd0, pc}, i % 16);
      check_eq("nop_fetch", {27'd0, mem_re, mem_address}, {27'd1, 4'(i % 16)});
      repeat (4) @(posedge clk);
      #1;
    end
    finish_run("nop", 4'd1, 0, 0);

    // Reset while the STA write strobe is up: write aborted, block idles until start.
    clear_img();
    img[0] = 8'h57; img[1] = 8'h4C; img[2] = 8'hF0; img[12] = 8'hAA;
    reset_and_load();
    pulse_start();
    begin
      int n = 0;
      while (!mem_we && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check_eq("sta_we_seen", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("abort_we", {30'd0, mem_we, mem_re}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("abort_ram12", {24'd0, ram[12]}, 32'hAA);
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_idle_pc", {28'd0, pc}, 32'd0);
    check_eq("abort_idle_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    check_eq("abort_halted", {31'd0, halted}, 32'd0);
    check_eq("abort_writes", wr_cnt, 32'd0);
    pulse_start();
    check_eq("restart_fetch", {27'd0, mem_re, mem_address}, {27'd1, 4'd0});
    reset = 1'b1;
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
